// File: rtl/ex_muldiv_pkg.sv
// Shared opcodes, flag bit positions and opcode decode helpers for the
// execute-stage multiply/divide unit.
package ex_muldiv_pkg;

  localparam logic [2:0] MD_OP_MULU_LO = 3'd0;
  localparam logic [2:0] MD_OP_MULU_HI = 3'd1;
  localparam logic [2:0] MD_OP_MULS_LO = 3'd2;
  localparam logic [2:0] MD_OP_MULS_HI = 3'd3;
  localparam logic [2:0] MD_OP_DIVU    = 3'd4;
  localparam logic [2:0] MD_OP_REMU    = 3'd5;
  localparam logic [2:0] MD_OP_DIVS    = 3'd6;
  localparam logic [2:0] MD_OP_REMS    = 3'd7;

  // Bit positions inside the {V,C,N,Z} flag vector
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  // The opcode is laid out as {div, signed, upper-half/remainder}
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return op[1];
  endfunction

  function automatic logic md_sel_upper(input logic [2:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_negate.sv
// Conditional two's-complement negation; used for operand magnitudes at
// accept and for sign restoration of the final product/quotient/remainder.
module ex_muldiv_negate #(
  parameter int W = 24
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Pass through, or invert-and-add-one when negation is requested
  always_comb begin
    val_o = neg_i ? (~val_i + ONE) : val_i;
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for the execute stage. Works on
// operand magnitudes, restores signs in a single fix-up cycle and returns
// the selected half/quotient/remainder with a tag and ZNCV flags.
import ex_muldiv_pkg::*;

module ex_muldiv_unit #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
) (
  input  logic             iw_clk,
  input  logic             iw_rst_n,
  input  logic             iw_flush,
  input  logic             iw_valid,
  output logic             ow_ready,
  input  logic [2:0]       iw_op,
  input  logic [WIDTH-1:0] iw_a,
  input  logic [WIDTH-1:0] iw_b,
  input  logic [TAG_W-1:0] iw_tag,
  output logic             ow_valid,
  input  logic             iw_ready,
  output logic [WIDTH-1:0] ow_result,
  output logic [TAG_W-1:0] ow_tag,
  output logic [3:0]       ow_flags,
  output logic             ow_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // acc holds the product upper half / partial remainder; lo holds the
  // multiplier being shifted out / dividend being shifted into the quotient
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcd_q, mcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             neg_q, neg_d;
  logic             v_q, v_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic [3:0]       flags_q, flags_d;

  // ---- accept-side decode ----
  logic             a_neg, b_neg, in_div, div_zero, div_ovf, special;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign in_div   = md_is_div(iw_op);
  assign a_neg    = md_is_signed(iw_op) & iw_a[WIDTH-1];
  assign b_neg    = md_is_signed(iw_op) & iw_b[WIDTH-1];
  assign div_zero = in_div && (iw_b == '0);
  assign div_ovf  = in_div && md_is_signed(iw_op) && (iw_a == MIN_NEG) && (iw_b == ALL_ONES);
  assign special  = div_zero | div_ovf;

  ex_muldiv_negate #(.W(WIDTH)) u_neg_a (.neg_i(a_neg), .val_i(iw_a), .val_o(a_mag));
  ex_muldiv_negate #(.W(WIDTH)) u_neg_b (.neg_i(b_neg), .val_i(iw_b), .val_o(b_mag));

  // ---- iteration step ----
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcd_q} : '0);
  assign div_shift = {acc_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, mcd_q});
  // Only consumed when div_ge, where the true difference fits in WIDTH bits
  assign div_diff  = div_shift[WIDTH-1:0] - mcd_q;

  // ---- fix-up: sign restore, selection, flags ----
  logic [2*WIDTH-1:0] fix_in, fix_out;
  logic [WIDTH-1:0]   fix_res, fix_hi, fix_lo;
  logic               fix_c;

  assign fix_in = !md_is_div(op_q)   ? {acc_q, lo_q} :
                  md_sel_upper(op_q) ? {{WIDTH{1'b0}}, acc_q} :
                                       {{WIDTH{1'b0}}, lo_q};

  ex_muldiv_negate #(.W(2*WIDTH)) u_neg_fix (.neg_i(neg_q), .val_i(fix_in), .val_o(fix_out));

  assign fix_hi  = fix_out[2*WIDTH-1:WIDTH];
  assign fix_lo  = fix_out[WIDTH-1:0];
  assign fix_res = (!md_is_div(op_q) && md_sel_upper(op_q)) ? fix_hi : fix_lo;
  // Low-half multiply lost information if the upper half isn't a plain extension
  assign fix_c   = !md_is_div(op_q) && !md_sel_upper(op_q) &&
                   (md_is_signed(op_q) ? (fix_hi != {WIDTH{fix_lo[WIDTH-1]}})
                                       : (fix_hi != '0));

  // State register with synchronous active-low reset
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state: special divides skip RUN but still take the fix-up cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (iw_valid) state_d = special ? S_FIX : S_RUN;
      S_RUN:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (iw_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (iw_flush) state_d = S_IDLE;
  end

  // Datapath next-state: latch at accept, iterate in RUN, publish in FIX
  always_comb begin
    acc_d   = acc_q;
    lo_d    = lo_q;
    mcd_d   = mcd_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    neg_d   = neg_q;
    v_d     = v_q;
    res_d   = res_q;
    otag_d  = otag_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: if (iw_valid) begin
        op_d  = iw_op;
        tag_d = iw_tag;
        cnt_d = CNT_INIT;
        if (div_zero) begin
          lo_d  = ALL_ONES;
          acc_d = iw_a;
          neg_d = 1'b0;
          v_d   = 1'b1;
        end else if (div_ovf) begin
          lo_d  = iw_a;
          acc_d = '0;
          neg_d = 1'b0;
          v_d   = 1'b1;
        end else begin
          acc_d = '0;
          lo_d  = in_div ? a_mag : b_mag;
          mcd_d = in_div ? b_mag : a_mag;
          // Remainder follows the dividend's sign; everything else the XOR
          neg_d = (in_div && md_sel_upper(iw_op)) ? a_neg : (a_neg ^ b_neg);
          v_d   = 1'b0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (md_is_div(op_q)) begin
          acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = mul_sum[WIDTH:1];
          lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        res_d          = fix_res;
        otag_d         = tag_q;
        flags_d        = '0;
        flags_d[FLG_Z] = (fix_res == '0);
        flags_d[FLG_N] = fix_res[WIDTH-1];
        flags_d[FLG_C] = fix_c;
        flags_d[FLG_V] = v_q;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge iw_clk) begin
    if (!iw_rst_n) begin
      acc_q   <= '0;
      lo_q    <= '0;
      mcd_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      neg_q   <= 1'b0;
      v_q     <= 1'b0;
      res_q   <= '0;
      otag_q  <= '0;
      flags_q <= '0;
    end else begin
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      mcd_q   <= mcd_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      neg_q   <= neg_d;
      v_q     <= v_d;
      res_q   <= res_d;
      otag_q  <= otag_d;
      flags_q <= flags_d;
    end
  end

  assign ow_ready  = (state_q == S_IDLE);
  assign ow_valid  = (state_q == S_DONE);
  assign ow_busy   = (state_q == S_RUN) || (state_q == S_FIX);
  assign ow_result = res_q;
  assign ow_tag    = otag_q;
  assign ow_flags  = flags_q;

endmodule
